// File: rtl/bsg_global_buffer_pkg.sv
// Shared definitions for the global-buffer ro/wo ring blocks.
// The ro address struct is the common field order ({x_cord, local_addr}) used by
// every block that drives or decodes ring addresses.
package bsg_global_buffer_pkg;

    // Width of an index into n entries, never less than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int gb_nodes_x_gp          = 4;
    localparam int gb_local_addr_width_gp = 10;
    localparam int gb_x_cord_width_gp     = safe_clog2(gb_nodes_x_gp);

    // Ring address for the default row geometry; dest_x occupies the MSBs.
    typedef struct packed {
        logic [gb_x_cord_width_gp-1:0]     x_cord;
        logic [gb_local_addr_width_gp-1:0] local_addr;
    } bsg_gb_ro_addr_s;

    // Requester watchdog states.
    typedef enum logic [1:0] {
        WD_IDLE = 2'd0,
        WD_WAIT = 2'd1,
        WD_TRIP = 2'd2
    } wd_state_e;

endpackage

// File: rtl/bsg_global_buffer_ro_resp_fifo.sv
// Return-data FIFO for the ro requester: els_p x data_width_p, one read and one
// write port. The ring cannot be stalled, so a push into a full FIFO without a
// simultaneous pop drops the data and sets a sticky overflow flag.
module bsg_global_buffer_ro_resp_fifo
    import bsg_global_buffer_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    push_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    pop_i,
    output logic [data_width_p-1:0] data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o
);

    localparam int ptr_width_lp = safe_clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [data_width_p-1:0] mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    wr_en, rd_en;

    assign full_o     = (count_q == cnt_width_lp'(els_p));
    assign empty_o    = (count_q == '0);
    assign data_o     = mem_q[rptr_q];
    assign overflow_o = overflow_q;

    // Pointer/occupancy update; a full FIFO still accepts a push when it pops that cycle.
    always_comb begin
        rd_en      = pop_i & ~empty_o;
        wr_en      = push_i & (~full_o | rd_en);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & full_o & ~rd_en);
        if (wr_en) begin
            wptr_d = (wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = (rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_global_buffer_ro_requester.sv
// Per-row read initiator at the west edge of the global-buffer ro ring.
// Injects {dest_x, local addr} into the ring one beat per accepted request and
// collects returns (in issue order) into a credit-protected FIFO.
// Optional watchdog: define BSG_GB_RO_REQUESTER_TIMEOUT_EN.
//
// Watchdog states:
//   state   | meaning
//   WD_IDLE | no reads outstanding, counter held at reload value
//   WD_WAIT | reads outstanding, counting down; reloaded on every ring return
//   WD_TRIP | no return for timeout_p cycles; error_o held until reset
module bsg_global_buffer_ro_requester
    import bsg_global_buffer_pkg::*;
#(
    parameter int nodes_x_p          = 4,
    parameter int local_addr_width_p = 10,
    parameter int data_width_p       = 32,
    parameter int els_p              = 4,
    parameter int timeout_p          = 64,
    localparam int x_cord_width_lp   = safe_clog2(nodes_x_p),
    localparam int addr_width_lp     = x_cord_width_lp + local_addr_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    output logic                     req_ready_o,
    output logic                     resp_v_o,
    output logic [data_width_p-1:0]  resp_data_o,
    input  logic                     resp_ready_i,
    output logic                     net_v_o,
    output logic [addr_width_lp-1:0] net_addr_o,
    input  logic                     net_v_i,
    input  logic [data_width_p-1:0]  net_data_i,
    output logic                     idle_o,
    output logic                     error_o
);

    localparam int credit_width_lp = $clog2(els_p + 1);

    // Same field order as bsg_gb_ro_addr_s, sized to this row's geometry.
    typedef struct packed {
        logic [x_cord_width_lp-1:0]    x_cord;
        logic [local_addr_width_p-1:0] local_addr;
    } ro_addr_s;

    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       net_v_q, net_v_d;
    ro_addr_s                   net_addr_q, net_addr_d;
    logic                       accept, dequeue;
    logic                       fifo_empty, fifo_full, fifo_overflow;
    logic                       timeout_trip;

    assign req_ready_o = (credits_q != '0);
    assign idle_o      = (credits_q == credit_width_lp'(els_p));
    assign accept      = req_v_i & req_ready_o;
    assign dequeue     = resp_v_o & resp_ready_i;
    assign net_v_o     = net_v_q;
    assign net_addr_o  = net_addr_q;
    assign resp_v_o    = ~fifo_empty;
    assign error_o     = fifo_overflow | timeout_trip;

    // Credit count and single-beat injection register.
    // Credits saturate at els_p so a stray ring return cannot wrap the count.
    always_comb begin
        credits_d  = credits_q;
        net_v_d    = accept;
        net_addr_d = accept ? ro_addr_s'(req_addr_i) : net_addr_q;
        if (accept && !dequeue) begin
            credits_d = credits_q - 1'b1;
        end else if (!accept && dequeue && !idle_o) begin
            credits_d = credits_q + 1'b1;
        end
    end

    // Requester state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q  <= credit_width_lp'(els_p);
            net_v_q    <= 1'b0;
            net_addr_q <= '0;
        end else begin
            credits_q  <= credits_d;
            net_v_q    <= net_v_d;
            net_addr_q <= net_addr_d;
        end
    end

    bsg_global_buffer_ro_resp_fifo #(
        .els_p        (els_p),
        .data_width_p (data_width_p)
    ) resp_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_i     (net_v_i),
        .data_i     (net_data_i),
        .pop_i      (dequeue),
        .data_o     (resp_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

`ifdef BSG_GB_RO_REQUESTER_TIMEOUT_EN
    localparam int wd_width_lp = safe_clog2(timeout_p);
    // Reload of timeout_p-2 accounts for the credit register and the cycle spent
    // entering WAIT, so the trip shows exactly timeout_p cycles after injection.
    localparam logic [wd_width_lp-1:0] wd_reload_lp = wd_width_lp'(timeout_p - 2);

    wd_state_e              wd_state_q, wd_state_d;
    logic [wd_width_lp-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog next-state: down-counter with terminal-count compare while waiting.
    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        case (wd_state_q)
            WD_IDLE: begin
                wd_cnt_d = wd_reload_lp;
                if (!idle_o) wd_state_d = WD_WAIT;
            end
            WD_WAIT: begin
                if (idle_o) begin
                    wd_state_d = WD_IDLE;
                    wd_cnt_d   = wd_reload_lp;
                end else if (net_v_i) begin
                    wd_cnt_d = wd_reload_lp;
                end else if (wd_cnt_q == '0) begin
                    wd_state_d = WD_TRIP;
                end else begin
                    wd_cnt_d = wd_cnt_q - 1'b1;
                end
            end
            WD_TRIP: wd_state_d = WD_TRIP;
            default: wd_state_d = WD_IDLE;
        endcase
    end

    // Watchdog state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_state_q <= WD_IDLE;
            wd_cnt_q   <= wd_reload_lp;
        end else begin
            wd_state_q <= wd_state_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign timeout_trip = (wd_state_q == WD_TRIP);
`else
    assign timeout_trip = 1'b0;
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_bsg_global_buffer_ro_requester.sv
// Directed bench for bsg_global_buffer_ro_requester (els_p=4, 12-bit address).
module tb_bsg_global_buffer_ro_requester;

    localparam int NX  = 4;
    localparam int LAW = 10;
    localparam int DW  = 32;
    localparam int ELS = 4;
    localparam int TO  = 64;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_v;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_v;
    logic [DW-1:0] resp_data;
    logic          resp_ready;
    logic          net_v_o;
    logic [AW-1:0] net_addr;
    logic          net_v_i;
    logic [DW-1:0] net_data;
    logic          idle;
    logic          error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_global_buffer_ro_requester #(
        .nodes_x_p          (NX),
        .local_addr_width_p (LAW),
        .data_width_p       (DW),
        .els_p              (ELS),
        .timeout_p          (TO)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .req_v_i      (req_v),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_data_o  (resp_data),
        .resp_ready_i (resp_ready),
        .net_v_o      (net_v_o),
        .net_addr_o   (net_addr),
        .net_v_i      (net_v_i),
        .net_data_i   (net_data),
        .idle_o       (idle),
        .error_o      (error)
    );

    typedef struct {
        logic          req_v;
        logic [AW-1:0] req_addr;
        logic          resp_ready;
        logic          net_v;
        logic [DW-1:0] net_data;
        logic          e_ready;
        logic          e_net_v;
        logic [AW-1:0] e_net_addr;
        logic          e_resp_v;
        logic [DW-1:0] e_resp_data;
        logic          e_idle;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rv, logic [AW-1:0] ra, logic rr, logic nv, logic [DW-1:0] nd,
                                logic er, logic env, logic [AW-1:0] ena, logic erv,
                                logic [DW-1:0] erd, logic ei, logic ee);
        vec_t v;
        v.req_v = rv; v.req_addr = ra; v.resp_ready = rr; v.net_v = nv; v.net_data = nd;
        v.e_ready = er; v.e_net_v = env; v.e_net_addr = ena; v.e_resp_v = erv;
        v.e_resp_data = erd; v.e_idle = ei; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_v = 1'b0; req_addr = '0; resp_ready = 1'b0; net_v_i = 1'b0; net_data = '0;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_idle", idle, 1);
        chk("reset_resp_v", resp_v, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single read, then two back-to-back reads with overlapping return/drain.
        tbl.push_back(mk(0, 12'h000, 0, 0, 0,          1, 0, 12'h000, 0, 0,          1, 0));
        tbl.push_back(mk(1, 12'h805, 0, 0, 0,          1, 1, 12'h805, 0, 0,          0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 12'h000, 0, 0, 0,      1, 0, 12'h805, 0, 0,          0, 0));
        tbl.push_back(mk(0, 12'h000, 0, 1, 32'hDEADBEEF, 1, 0, 12'h805, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 12'h000, 1, 0, 0,          1, 0, 12'h805, 0, 0,          1, 0));
        tbl.push_back(mk(1, 12'h123, 0, 0, 0,          1, 1, 12'h123, 0, 0,          0, 0));
        tbl.push_back(mk(1, 12'h3FF, 0, 0, 0,          1, 1, 12'h3FF, 0, 0,          0, 0));
        tbl.push_back(mk(0, 12'h000, 0, 1, 32'hA1,     1, 0, 12'h3FF, 1, 32'hA1,     0, 0));
        tbl.push_back(mk(0, 12'h000, 1, 1, 32'hA2,     1, 0, 12'h3FF, 1, 32'hA2,     0, 0));
        tbl.push_back(mk(0, 12'h000, 1, 0, 0,          1, 0, 12'h3FF, 0, 0,          1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_v = tbl[i].req_v; req_addr = tbl[i].req_addr; resp_ready = tbl[i].resp_ready;
            net_v_i = tbl[i].net_v; net_data = tbl[i].net_data;
            step();
            chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("v%0d_net_v", i), net_v_o, tbl[i].e_net_v);
            chk($sformatf("v%0d_net_addr", i), net_addr, tbl[i].e_net_addr);
            chk($sformatf("v%0d_resp_v", i), resp_v, tbl[i].e_resp_v);
            if (tbl[i].e_resp_v)
                chk($sformatf("v%0d_resp_data", i), resp_data, tbl[i].e_resp_data);
            chk($sformatf("v%0d_idle", i), idle, tbl[i].e_idle);
            chk($sformatf("v%0d_err", i), error, tbl[i].e_err);
        end
        quiet();

        // Credit limit: five back-to-back requests, only four accepted.
        for (int i = 0; i < 5; i++) begin
            req_v = 1'b1; req_addr = AW'(12'h100 + i);
            #1;
            chk($sformatf("cred_ready%0d", i), req_ready, (i < 4) ? 1 : 0);
            step();
            chk($sformatf("cred_net_v%0d", i), net_v_o, (i < 4) ? 1 : 0);
            if (i < 4) chk($sformatf("cred_addr%0d", i), net_addr, 12'h100 + i);
        end
        quiet();
        step();
        chk("cred_ready_after", req_ready, 0);
        chk("cred_net_v_after", net_v_o, 0);
        chk("cred_idle_after", idle, 0);

        // Ordering with backpressure: fill the FIFO, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            net_v_i = 1'b1; net_data = DW'(i);
            step();
        end
        net_v_i = 1'b0;
        chk("ord_full_resp_v", resp_v, 1);
        chk("ord_full_head", resp_data, 1);
        chk("ord_full_err", error, 0);
        resp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ord_data%0d", i), resp_data, i);
            step();
        end
        resp_ready = 1'b0;
        chk("ord_drained_resp_v", resp_v, 0);
        chk("ord_idle", idle, 1);
        chk("ord_ready", req_ready, 1);
        chk("ord_err", error, 0);

        // Simultaneous push/pop on a full FIFO, then a forced overflow.
        for (int i = 0; i < 4; i++) begin
            req_v = 1'b1; req_addr = AW'(12'h200 + i);
            step();
        end
        req_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            net_v_i = 1'b1; net_data = DW'(32'hB0 + i);
            step();
        end
        net_v_i = 1'b1; net_data = 32'hB4; resp_ready = 1'b1;
        step();
        chk("sim_err", error, 0);
        chk("sim_head", resp_data, 32'hB1);
        net_v_i = 1'b1; net_data = 32'hB5; resp_ready = 1'b0;
        step();
        chk("ovf_err", error, 1);
        net_v_i = 1'b0; resp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_resp_v%0d", i), resp_v, 1);
            chk($sformatf("ovf_data%0d", i), resp_data, 32'hB0 + i);
            step();
        end
        resp_ready = 1'b0;
        chk("ovf_empty", resp_v, 0);
        chk("ovf_sticky", error, 1);

        // Asynchronous reset in the middle of traffic.
        req_v = 1'b1; req_addr = 12'h0AA;
        step();
        net_v_i = 1'b1; net_data = 32'h77;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_net_v", net_v_o, 0);
        chk("arst_net_addr", net_addr, 0);
        chk("arst_resp_v", resp_v, 0);
        chk("arst_idle", idle, 1);
        chk("arst_err", error, 0);
        quiet();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Watchdog: one request that never returns.
        req_v = 1'b1; req_addr = 12'h042;
        step();
        quiet();
`ifdef BSG_GB_RO_REQUESTER_TIMEOUT_EN
        for (int k = 1; k <= 63; k++) step();
        chk("wd_before_trip", error, 0);
        step();
        chk("wd_trip", error, 1);
`else
        for (int k = 1; k <= 80; k++) step();
        chk("wd_absent_err", error, 0);
`endif
        chk("wd_outstanding", idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
